i2c_slave_mem: RTL and testbench

// - I2C target (slave) with a 128x8 byte memory; the device on the far end of the sda/scl bus from the I2C master.
// - Decodes START/STOP; takes the 7-bit address field as the memory location; ACKs it; then writes or returns one byte.
// - Drives sda open-drain (low or 'z'); never drives scl; no clock stretching.

---
 rtl/i2c_slave_mem.sv | 251 +++++++++++++++++++++++++
 tb/tb_i2c_slave_mem.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_mem.sv
// I2C target with a 2**addrWidth x 8 byte memory. The 7-bit address field of
// each transfer is the memory location; one byte (or a burst) is written/read.
// Build option: define I2C_SLV_BURST_EN for multi-byte transfers with an
// auto-incrementing, wrapping pointer; undefined gives single-byte transfers.
// Ports:
//   clk      system clock (>= 10x scl)
//   rst      synchronous active-low reset
//   scl      I2C clock, observed only
//   sda      I2C data, open-drain (0 or z)
//   busy     high from START to STOP
//   done     1-clk pulse at STOP when a data byte completed
//   memWe    1-clk strobe when a written byte commits
//   memAddr  address of last committed or served byte
//   memWdata data of last committed write
module i2c_slave_mem #(
  parameter int addrWidth  = 7,
  parameter int dataWidth  = 8,
  parameter int syncStages = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  inout  wire                  scl,
  inout  wire                  sda,
  output logic                 busy,
  output logic                 done,
  output logic                 memWe,
  output logic [addrWidth-1:0] memAddr,
  output logic [dataWidth-1:0] memWdata
);

  localparam int depth = 2 ** addrWidth;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } state_t;

  state_t state;

  logic [syncStages-1:0] sclSh;
  logic [syncStages-1:0] sdaSh;
  logic                  sclD;
  logic                  sdaD;
  logic                  sclSync;
  logic                  sdaSync;
  logic                  sclRise;
  logic                  sclFall;
  logic                  sdaRise;
  logic                  sdaFall;
  logic                  startC;
  logic                  stopC;

  logic [dataWidth-1:0]  mem [depth];
  logic [dataWidth-1:0]  shift;
  logic [dataWidth-1:0]  inByte;
  logic [dataWidth-1:0]  rdCur;
  logic [addrWidth-1:0]  ptr;
  logic [2:0]            bitCnt;
  logic [1:0]            ph;
  logic                  rw;
  logic                  sdaOe;
  logic                  gotData;

`ifdef I2C_SLV_BURST_EN
  logic [addrWidth-1:0]  ptrNxt;
  logic [dataWidth-1:0]  rdNxt;
  assign ptrNxt = ptr + addrWidth'(1);
  assign rdNxt  = mem[ptrNxt];
`endif

  assign sda = sdaOe ? 1'b0 : 1'bz;

  assign sclSync = sclSh[syncStages-1];
  assign sdaSync = sdaSh[syncStages-1];
  assign sclRise = sclSync & ~sclD;
  assign sclFall = ~sclSync & sclD;
  assign sdaRise = sdaSync & ~sdaD;
  assign sdaFall = ~sdaSync & sdaD;
  assign startC  = sdaFall & sclSync;
  assign stopC   = sdaRise & sclSync;

  assign inByte  = {shift[dataWidth-2:0], sdaSync};
  assign rdCur   = mem[ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      sclSh    <= '1;
      sdaSh    <= '1;
      sclD     <= 1'b1;
      sdaD     <= 1'b1;
      state    <= IDLE;
      shift    <= '0;
      ptr      <= '0;
      bitCnt   <= '0;
      ph       <= '0;
      rw       <= 1'b0;
      sdaOe    <= 1'b0;
      gotData  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
      for (int i = 0; i < depth; i++) begin
        mem[i] <= '0;
      end
    end else begin
      sclSh <= {sclSh[syncStages-2:0], scl};
      sdaSh <= {sdaSh[syncStages-2:0], sda};
      sclD  <= sclSync;
      sdaD  <= sdaSync;
      done  <= 1'b0;
      memWe <= 1'b0;
      if (stopC) begin
        state   <= IDLE;
        busy    <= 1'b0;
        sdaOe   <= 1'b0;
        ph      <= '0;
        done    <= gotData;
        gotData <= 1'b0;
      end else if (startC) begin
        // repeated START drops any partial byte
        if (state == IDLE) begin
          gotData <= 1'b0;
        end
        state  <= ADDR;
        busy   <= 1'b1;
        sdaOe  <= 1'b0;
        bitCnt <= '0;
        ph     <= '0;
      end else begin
        unique case (state)
          IDLE, WAIT_STOP: ;
          ADDR: begin
            if (sclRise) begin
              shift  <= inByte;
              bitCnt <= bitCnt + 3'd1;
              if (bitCnt == 3'd7) begin
                ptr   <= shift[addrWidth-1:0];
                rw    <= sdaSync;
                ph    <= '0;
                state <= ADDR_ACK;
              end
            end
          end
          ADDR_ACK: begin
            // first fall: drive ACK; second fall: hand over
            if (sclFall) begin
              if (ph == 2'd0) begin
                sdaOe <= 1'b1;
                ph    <= 2'd1;
              end else begin
                ph     <= '0;
                bitCnt <= '0;
                if (rw) begin
                  shift   <= rdCur;
                  sdaOe   <= ~rdCur[dataWidth-1];
                  memAddr <= ptr;
                  state   <= RD_DATA;
                end else begin
                  sdaOe <= 1'b0;
                  state <= WR_DATA;
                end
              end
            end
          end
          WR_DATA: begin
            if (sclRise) begin
              shift  <= inByte;
              bitCnt <= bitCnt + 3'd1;
              if (bitCnt == 3'd7) begin
                mem[ptr] <= inByte;
                memWe    <= 1'b1;
                memAddr  <= ptr;
                memWdata <= inByte;
                gotData  <= 1'b1;
                ph       <= '0;
                state    <= WR_ACK;
              end
            end
          end
          WR_ACK: begin
            if (sclFall) begin
              if (ph == 2'd0) begin
                sdaOe <= 1'b1;
                ph    <= 2'd1;
              end else begin
                sdaOe <= 1'b0;
                ph    <= '0;
`ifdef I2C_SLV_BURST_EN
                ptr    <= ptrNxt;
                bitCnt <= '0;
                state  <= WR_DATA;
`else
                state  <= WAIT_STOP;
`endif
              end
            end
          end
          RD_DATA: begin
            if (sclRise) begin
              bitCnt <= bitCnt + 3'd1;
              if (bitCnt == 3'd7) begin
                gotData <= 1'b1;
                ph      <= '0;
                state   <= RD_ACK;
              end
            end else if (sclFall) begin
              shift <= shift << 1;
              sdaOe <= ~shift[dataWidth-2];
            end
          end
          RD_ACK: begin
            if (sclFall && ph == 2'd0) begin
              sdaOe <= 1'b0;
              ph    <= 2'd1;
            end else if (sclRise && ph == 2'd1) begin
`ifdef I2C_SLV_BURST_EN
              if (!sdaSync) begin
                ph <= 2'd2;
              end else begin
                state <= WAIT_STOP;
              end
`else
              state <= WAIT_STOP;
`endif
            end
`ifdef I2C_SLV_BURST_EN
            else if (sclFall && ph == 2'd2) begin
              ptr     <= ptrNxt;
              shift   <= rdNxt;
              sdaOe   <= ~rdNxt[dataWidth-1];
              memAddr <= ptrNxt;
              bitCnt  <= '0;
              ph      <= '0;
              state   <= RD_DATA;
            end
`endif
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_mem.sv
// Bench for i2c_slave_mem: bit-banged I2C master, table of single-byte
// transfers, plus repeated-start, NACK, mid-read reset and burst sequences.
module tb_i2c_slave_mem;

  localparam int Q = 8;
`ifdef I2C_SLV_BURST_EN
  localparam bit burst = 1'b1;
`else
  localparam bit burst = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclDrv = 1'b1;
  logic       sdaDrv = 1'b1;
  wire        scl;
  wire        sda;
  logic       busy;
  logic       done;
  logic       memWe;
  logic [6:0] memAddr;
  logic [7:0] memWdata;

  int total = 0;
  int bad = 0;
  int doneCnt = 0;
  int weCnt = 0;

  typedef struct packed {
    logic [6:0] a;
    logic [7:0] d;
  } wr_t;

  typedef struct {
    logic       rd;
    logic [6:0] a;
    logic [7:0] d;
  } vec_t;

  wr_t        expWr[$];
  logic [7:0] expRd[$];
  vec_t       tbl[9];

  assign scl = sclDrv ? 1'bz : 1'b0;
  assign sda = sdaDrv ? 1'bz : 1'b0;
  pullup (scl);
  pullup (sda);

  always #5 clk = ~clk;

  i2c_slave_mem dut (
    .clk(clk),
    .rst(rst),
    .scl(scl),
    .sda(sda),
    .busy(busy),
    .done(done),
    .memWe(memWe),
    .memAddr(memAddr),
    .memWdata(memWdata)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t w;
    if (done) doneCnt++;
    if (rst && memWe) begin
      weCnt++;
      if (expWr.size() == 0) begin
        total++;
        bad++;
        $display("FAIL memWe unexpected: addr %0h data %0h",
                 memAddr, memWdata);
      end else begin
        w = expWr.pop_front();
        chk("memWe addr", 32'(memAddr), 32'(w.a));
        chk("memWe data", 32'(memWdata), 32'(w.d));
      end
    end
  end

  task automatic waitq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2cStart();
    if (sclDrv == 1'b0) begin
      sdaDrv = 1'b1;
      waitq();
      sclDrv = 1'b1;
      waitq();
    end
    sdaDrv = 1'b0;
    waitq();
    sclDrv = 1'b0;
    waitq();
  endtask

  task automatic i2cStop();
    sdaDrv = 1'b0;
    waitq();
    sclDrv = 1'b1;
    waitq();
    sdaDrv = 1'b1;
    waitq();
  endtask

  task automatic bitx(input logic b, output logic r);
    sdaDrv = b;
    waitq();
    sclDrv = 1'b1;
    waitq();
    r = sda;
    waitq();
    sclDrv = 1'b0;
    waitq();
  endtask

  task automatic wrByte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bitx(b[i], r);
    bitx(1'b1, ack);
  endtask

  task automatic rdByte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bitx(1'b1, r);
      d[i] = r;
    end
    bitx(mack, r);
  endtask

  task automatic txWrite(input logic [6:0] a, input logic [7:0] d);
    logic ack;
    int   d0;
    d0 = doneCnt;
    i2cStart();
    chk("busy after start", 32'(busy), 1);
    expWr.push_back({a, d});
    wrByte({a, 1'b0}, ack);
    chk("wr addr ack", 32'(ack), 0);
    wrByte(d, ack);
    chk("wr data ack", 32'(ack), 0);
    i2cStop();
    waitq();
    chk("busy after stop", 32'(busy), 0);
    chk("wr done pulses", 32'(doneCnt - d0), 1);
    chk("wr queue drained", 32'(expWr.size()), 0);
  endtask

  task automatic txRead(input logic [6:0] a, input logic [7:0] e);
    logic       ack;
    logic [7:0] d;
    int         d0;
    d0 = doneCnt;
    expRd.push_back(e);
    i2cStart();
    wrByte({a, 1'b1}, ack);
    chk("rd addr ack", 32'(ack), 0);
    rdByte(1'b1, d);
    chk("rd data", 32'(d), 32'(expRd.pop_front()));
    i2cStop();
    waitq();
    chk("rd done pulses", 32'(doneCnt - d0), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic       ack;
    logic       r;
    logic [7:0] d;
    int         d0;
    int         w0;

    tbl[0] = '{1'b1, 7'h15, 8'h00};
    tbl[1] = '{1'b0, 7'h3C, 8'hA5};
    tbl[2] = '{1'b1, 7'h3C, 8'hA5};
    tbl[3] = '{1'b0, 7'h00, 8'h5A};
    tbl[4] = '{1'b1, 7'h00, 8'h5A};
    tbl[5] = '{1'b0, 7'h7F, 8'hC3};
    tbl[6] = '{1'b1, 7'h7F, 8'hC3};
    tbl[7] = '{1'b0, 7'h10, 8'h77};
    tbl[8] = '{1'b1, 7'h10, 8'h77};

    repeat (4) @(negedge clk);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset memWe", 32'(memWe), 0);
    chk("reset memAddr", 32'(memAddr), 0);
    chk("reset memWdata", 32'(memWdata), 0);
    chk("reset sda", 32'(sda), 1);
    rst = 1'b1;
    waitq();

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].rd) txRead(tbl[i].a, tbl[i].d);
      else txWrite(tbl[i].a, tbl[i].d);
    end

    // partial write cut by repeated START, then read back
    d0 = doneCnt;
    w0 = weCnt;
    i2cStart();
    wrByte({7'h10, 1'b0}, ack);
    chk("rs addr ack", 32'(ack), 0);
    bitx(1'b0, r);
    bitx(1'b1, r);
    bitx(1'b0, r);
    bitx(1'b0, r);
    i2cStart();
    wrByte({7'h10, 1'b1}, ack);
    chk("rs rd addr ack", 32'(ack), 0);
    rdByte(1'b1, d);
    chk("rs old value", 32'(d), 32'h77);
    i2cStop();
    waitq();
    chk("rs no memWe", 32'(weCnt - w0), 0);
    chk("rs done pulses", 32'(doneCnt - d0), 1);

    // master NACK keeps sda released until STOP
    d0 = doneCnt;
    i2cStart();
    wrByte({7'h3C, 1'b1}, ack);
    chk("nack addr ack", 32'(ack), 0);
    rdByte(1'b1, d);
    chk("nack data", 32'(d), 32'hA5);
    bitx(1'b1, r);
    chk("nack released 1", 32'(r), 1);
    bitx(1'b1, r);
    chk("nack released 2", 32'(r), 1);
    chk("nack busy", 32'(busy), 1);
    i2cStop();
    waitq();
    chk("nack done pulses", 32'(doneCnt - d0), 1);

    // reset while the slave drives bit 7 (=0) of 8'h5A
    i2cStart();
    wrByte({7'h00, 1'b1}, ack);
    chk("mr addr ack", 32'(ack), 0);
    chk("mr slave drives", 32'(sda), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mr sda released", 32'(sda), 1);
    chk("mr busy", 32'(busy), 0);
    chk("mr memWdata", 32'(memWdata), 0);
    chk("mr done", 32'(done), 0);
    sclDrv = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    waitq();
    txRead(7'h00, 8'h00);
    txRead(7'h3C, 8'h00);
    txRead(7'h7F, 8'h00);
    txRead(7'h10, 8'h00);

    // three-byte write from 7'h7F
    d0 = doneCnt;
    i2cStart();
    expWr.push_back({7'h7F, 8'h11});
    if (burst) begin
      expWr.push_back({7'h00, 8'h22});
      expWr.push_back({7'h01, 8'h33});
    end
    wrByte({7'h7F, 1'b0}, ack);
    chk("bw addr ack", 32'(ack), 0);
    wrByte(8'h11, ack);
    chk("bw ack 1", 32'(ack), 0);
    wrByte(8'h22, ack);
    chk("bw ack 2", 32'(ack), burst ? 0 : 1);
    wrByte(8'h33, ack);
    chk("bw ack 3", 32'(ack), burst ? 0 : 1);
    i2cStop();
    waitq();
    chk("bw done pulses", 32'(doneCnt - d0), 1);
    chk("bw queue drained", 32'(expWr.size()), 0);
    txRead(7'h7F, 8'h11);
    txRead(7'h00, burst ? 8'h22 : 8'h00);
    txRead(7'h01, burst ? 8'h33 : 8'h00);

    // three-byte read from 7'h7F, ACK, ACK, NACK
    d0 = doneCnt;
    i2cStart();
    wrByte({7'h7F, 1'b1}, ack);
    chk("br addr ack", 32'(ack), 0);
    rdByte(1'b0, d);
    chk("br byte 1", 32'(d), 32'h11);
    rdByte(1'b0, d);
    chk("br byte 2", 32'(d), burst ? 32'h22 : 32'hFF);
    rdByte(1'b1, d);
    chk("br byte 3", 32'(d), burst ? 32'h33 : 32'hFF);
    i2cStop();
    waitq();
    chk("br done pulses", 32'(doneCnt - d0), 1);
    chk("final wr queue", 32'(expWr.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
